lora_tx_frame: RTL and testbench

//  Command-frame transmitter toward the LoRa module. It is the upstream partner of the LoRa receive

---
 rtl/lora_tx_frame.sv | 144 ++++++++++++++
 tb/tb_lora_tx_frame.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lora_tx_frame.sv
// Sends the 5-byte {HEAD, cmd, data, cmd^data, TAIL} frame as 8N1 UART. A frame is accepted on a sampled tx_start,
// runs for 50*BPS_CNT line clocks, and then gives a DONE pulse. tx_start is ignored while busy.
module lora_tx_frame #(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 115200,
  parameter logic [7:0] FRAME_HEAD = 8'hAA,
  parameter logic [7:0] FRAME_TAIL = 8'h55
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_cmd,
  input  logic [7:0] tx_data,
  output logic       uart_txd,
  output logic       busy_tx,
  output logic       over_tx
);

  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BPS_CNT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    data_q, data_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          over_q, over_d;
  logic          bit_end;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] byte_sel(input logic [2:0] idx, input logic [7:0] c, input logic [7:0] d);
    case (idx)
      3'd0:    byte_sel = FRAME_HEAD;
      3'd1:    byte_sel = c;
      3'd2:    byte_sel = d;
      3'd3:    byte_sel = c ^ d;
      default: byte_sel = FRAME_TAIL;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    bit_end = (baud_q == CW'(BPS_CNT - 1));

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (tx_start) begin
          cmd_d   = tx_cmd;
          data_d  = tx_data;
          byte_d  = 3'd0;
          bit_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      S_STOP: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (byte_q == 3'd4) begin
            state_d = S_DONE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
          end
        end
      end
      S_DONE: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    // Line level is derived from the next state so the start bit appears the cycle after acceptance.
    cur_byte = byte_sel(byte_d, cmd_d, data_d);
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = cur_byte[bit_d];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      cmd_q   <= 8'h00;
      data_q  <= 8'h00;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      over_q  <= over_d;
    end
  end

  assign uart_txd = txd_q;
  assign busy_tx  = busy_q;
  assign over_tx  = over_q;

endmodule

// File: tb/tb_lora_tx_frame.sv
// Bench for lora_tx_frame: a frame-level model queues expected bytes and over_tx times.
// A UART decoder pops and compares them as the line produces bytes.
module tb_lora_tx_frame;

  localparam int BPS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_cmd = 8'h00;
  logic [7:0] tx_data = 8'h00;
  logic       uart_txd, busy_tx, over_tx;

  always #5 clk = ~clk;

  lora_tx_frame #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_cmd   (tx_cmd),
    .tx_data  (tx_data),
    .uart_txd (uart_txd),
    .busy_tx  (busy_tx),
    .over_tx  (over_tx)
  );

  typedef struct {
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   over_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   busy_at = -1;
  int   idle_from = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame accepted at cycle A puts byte i on the line from A+i*10*BPS and raises over_tx at A+50*BPS.
  // The next frame may be accepted from A+50*BPS+2.
  initial begin
    logic [7:0] fr [5];
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        over_q.delete();
        idle_from = 0;
        busy_at = -1;
      end else if (tx_start && cyc >= idle_from) begin
        fr[0] = 8'hAA;
        fr[1] = tx_cmd;
        fr[2] = tx_data;
        fr[3] = tx_cmd ^ tx_data;
        fr[4] = 8'h55;
        for (int i = 0; i < 5; i++) exp_q.push_back('{b: fr[i], at: cyc + 10 * BPS * i});
        over_q.push_back(cyc + 50 * BPS);
        busy_at = cyc;
        idle_from = cyc + 50 * BPS + 2;
      end
    end
  end

  // Monitor: decode 8N1 bytes on the line and check over_tx.
  initial begin
    bit         dec_active = 0;
    bit         width_bad = 0;
    logic       prev = 1'b1;
    logic       lvl = 1'b1;
    logic       stop_v = 1'b1;
    logic [7:0] shreg = 8'h00;
    int         dec_pos = 0;
    int         start_cyc = 0;
    int         bn;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dec_active = 0;
        prev = 1'b1;
      end else begin
        if (!dec_active && prev === 1'b1 && uart_txd === 1'b0) begin
          dec_active = 1;
          dec_pos = 0;
          width_bad = 0;
          start_cyc = cyc;
        end
        if (dec_active) begin
          bn = dec_pos / BPS;
          if (dec_pos % BPS == 0) begin
            lvl = uart_txd;
            if (bn >= 1 && bn <= 8) shreg[bn-1] = uart_txd;
            if (bn == 9) stop_v = uart_txd;
          end else if (uart_txd !== lvl) begin
            width_bad = 1;
          end
          dec_pos++;
          if (dec_pos == 10 * BPS) begin
            dec_active = 0;
            if (exp_q.size() == 0) begin
              checks++;
              fails++;
              $display("FAIL unexpected_byte: got 0x%0h, none expected (cycle %0d)", shreg, cyc);
            end else begin
              e = exp_q.pop_front();
              check("byte_value", int'(shreg), int'(e.b));
              check("byte_start_cycle", start_cyc, e.at);
              check("bit_width", int'(width_bad), 0);
              check("stop_bit", int'(stop_v), 1);
            end
          end
        end
        prev = uart_txd;
        if (over_tx === 1'b1) begin
          if (over_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_over_tx: got 1, expected 0 (cycle %0d)", cyc);
          end else begin
            check("over_tx_cycle", cyc, over_q.pop_front());
            check("busy_in_done", int'(busy_tx), 0);
          end
        end
        if (cyc == busy_at) check("busy_rise", int'(busy_tx), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] d);
    tx_cmd = c;
    tx_data = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  initial begin
    bit idle_bad = 0;
    int g;

    repeat (3) tick();
    check("reset_txd", int'(uart_txd), 1);
    check("reset_busy", int'(busy_tx), 0);
    check("reset_over", int'(over_tx), 0);
    rst_n = 1'b1;

    repeat (100) begin
      tick();
      if (uart_txd !== 1'b1 || busy_tx !== 1'b0 || over_tx !== 1'b0) idle_bad = 1;
    end
    check("idle_quiet", int'(idle_bad), 0);

    send(8'h01, 8'h02);
    repeat (520) tick();

    // A second request mid-frame with a new cmd must be dropped.
    send(8'h01, 8'h02);
    repeat (199) tick();
    tx_cmd = 8'hFF;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (320) tick();

    send(8'h01, 8'h02);
    tx_data = 8'h7E;
    repeat (520) tick();

    send(8'h3C, 8'hC3);
    repeat (137) tick();
    rst_n = 1'b0;
    #1;
    check("abort_txd", int'(uart_txd), 1);
    check("abort_busy", int'(busy_tx), 0);
    check("abort_over", int'(over_tx), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    send(8'h12, 8'h34);
    repeat (520) tick();

    tx_cmd = 8'hA5;
    tx_data = 8'h5A;
    tx_start = 1'b1;
    repeat (600) tick();
    tx_start = 1'b0;
    repeat (520) tick();

    for (int n = 0; n < 6; n++) begin
      send(8'($urandom), 8'($urandom));
      g = $urandom_range(1, 400);
      repeat (g) tick();
      tx_cmd = 8'($urandom);
      tx_data = 8'($urandom);
      tx_start = 1'($urandom_range(0, 1));
      tick();
      tx_start = 1'b0;
      repeat (520 - g + $urandom_range(0, 5)) tick();
    end

    repeat (20) tick();
    check("pending_bytes", exp_q.size(), 0);
    check("pending_over", over_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
